// File: rtl/alu_pkg.sv
// Shared op-codes, FSM state type and op-class helpers for the sequential ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // 11xx op-codes are reserved
    function automatic logic op_is_illegal(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between the control FSM and the sequential ALU.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Op1;
    logic [WIDTH-1:0] Op2;
    logic [3:0]       S_Op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R_Op;
    logic [WIDTH-1:0] R_Hi;
    logic             ZF;
    logic             DZ;
    logic             ILL;

    modport master (
        output in_valid, Op1, Op2, S_Op, out_ready,
        input  in_ready, out_valid, R_Op, R_Hi, ZF, DZ, ILL
    );

    modport slave (
        input  in_valid, Op1, Op2, S_Op, out_ready,
        output in_ready, out_valid, R_Op, R_Hi, ZF, DZ, ILL
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned MUL (shift-add) / DIV (restoring), one bit per cycle.
// Latency: load on start, WIDTH iterations; done is high with the final lo/hi on the last one.
// Backpressure: none; the caller must capture lo/hi in the cycle done is high.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic             is_div;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    // One iteration step: the final step's result is exported directly so the
    // caller can register it without waiting an extra cycle.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = div_shift >= {1'b0, b_q};
        if (is_div) begin
            nxt_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    assign done = busy && (cnt == CW'(WIDTH - 1));
    assign lo   = nxt_lo;
    assign hi   = nxt_hi;

    // Accumulator: {hi,lo} is the 2*WIDTH product register for MUL and
    // {remainder, dividend/quotient} for DIV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            is_div <= 1'b0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            b_q    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            is_div <= (op == OP_DIV);
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= a;
            b_q    <= b;
        end else if (busy) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative MUL/DIV, one op in flight.
// Latency: 1 cycle for single-cycle/illegal/divide-by-zero, WIDTH+1 for MUL and DIV.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_seq_if.slave    bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             iter_path;
    logic             eng_start;
    logic             eng_done;
    logic [WIDTH-1:0] eng_lo;
    logic [WIDTH-1:0] eng_hi;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_lo;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_dz;
    logic             sc_ill;

    logic [WIDTH-1:0] r_op_q;
    logic [WIDTH-1:0] r_hi_q;
    logic             zf_q;
    logic             dz_q;
    logic             ill_q;

    // MUL always iterates; DIV iterates unless the divisor is zero.
    assign iter_path = (bus.S_Op == OP_MUL) || ((bus.S_Op == OP_DIV) && (bus.Op2 != '0));
    assign accept    = (state == IDLE) && bus.in_valid;
    assign eng_start = accept && iter_path;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (eng_start),
        .op    (bus.S_Op),
        .a     (bus.Op1),
        .b     (bus.Op2),
        .done  (eng_done),
        .lo    (eng_lo),
        .hi    (eng_hi)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = iter_path ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (eng_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle results, evaluated on the live operands at the accept edge
    always_comb begin
        shamt  = bus.Op2[SHW-1:0];
        sc_lo  = '0;
        sc_hi  = '0;
        sc_dz  = 1'b0;
        sc_ill = 1'b0;
        case (bus.S_Op)
            OP_ADD: sc_lo = bus.Op1 + bus.Op2;
            OP_SUB: sc_lo = bus.Op1 - bus.Op2;
            OP_DIV: begin
                // only captured when the divisor is zero
                sc_lo = '1;
                sc_hi = bus.Op1;
                sc_dz = 1'b1;
            end
            OP_OR:  sc_lo = bus.Op1 | bus.Op2;
            OP_AND: sc_lo = bus.Op1 & bus.Op2;
            OP_SLT: sc_lo = {{(WIDTH-1){1'b0}}, (bus.Op1 < bus.Op2)};
            OP_SLL: sc_lo = bus.Op1 << shamt;
            OP_SRL: sc_lo = bus.Op1 >> shamt;
            OP_SRA: sc_lo = $unsigned($signed(bus.Op1) >>> shamt);
            OP_XOR: sc_lo = bus.Op1 ^ bus.Op2;
            OP_NOR: sc_lo = ~(bus.Op1 | bus.Op2);
            OP_MUL: sc_lo = '0;
            default: sc_ill = op_is_illegal(bus.S_Op);
        endcase
    end

    // Result registers: loaded at accept for single-cycle ops, or on the
    // engine's final iteration; untouched while DONE so outputs stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_q <= '0;
            r_hi_q <= '0;
            zf_q   <= 1'b1;
            dz_q   <= 1'b0;
            ill_q  <= 1'b0;
        end else if (accept && !iter_path) begin
            r_op_q <= sc_lo;
            r_hi_q <= sc_hi;
            zf_q   <= (sc_lo == '0);
            dz_q   <= sc_dz;
            ill_q  <= sc_ill;
        end else if ((state == BUSY) && eng_done) begin
            r_op_q <= eng_lo;
            r_hi_q <= eng_hi;
            zf_q   <= (eng_lo == '0);
            dz_q   <= 1'b0;
            ill_q  <= 1'b0;
        end
    end

    assign bus.R_Op = r_op_q;
    assign bus.R_Hi = r_hi_q;
    assign bus.ZF   = zf_q;
    assign bus.DZ   = dz_q;
    assign bus.ILL  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=32: directed cases plus random ops against an arithmetic model.
// Latency: measured in negedges from the accept edge to first out_valid.
// Backpressure: random out_ready stalls with in_valid toggling while DONE.
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zf;
        logic        dz;
        logic        ill;
        int          lat;
    } res_t;

    // Reference: plain arithmetic on the op definitions
    function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        logic [63:0] prod;
        logic [4:0]  sh;
        sh    = b[4:0];
        r.lo  = 32'd0;
        r.hi  = 32'd0;
        r.dz  = 1'b0;
        r.ill = 1'b0;
        r.lat = 1;
        case (op)
            4'd0:  r.lo = a + b;
            4'd1:  r.lo = a - b;
            4'd2: begin
                prod  = 64'(a) * 64'(b);
                r.lo  = prod[31:0];
                r.hi  = prod[63:32];
                r.lat = 33;
            end
            4'd3: begin
                if (b == 32'd0) begin
                    r.lo = 32'hFFFF_FFFF;
                    r.hi = a;
                    r.dz = 1'b1;
                end else begin
                    r.lo  = a / b;
                    r.hi  = a % b;
                    r.lat = 33;
                end
            end
            4'd4:  r.lo = a | b;
            4'd5:  r.lo = a & b;
            4'd6:  r.lo = (a < b) ? 32'd1 : 32'd0;
            4'd7:  r.lo = a << sh;
            4'd8:  r.lo = a >> sh;
            4'd9:  r.lo = $unsigned($signed(a) >>> sh);
            4'd10: r.lo = a ^ b;
            4'd11: r.lo = ~(a | b);
            default: r.ill = 1'b1;
        endcase
        r.zf = (r.lo == 32'd0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, check latency/result, optionally stall in DONE for 'hold' cycles
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        res_t        e;
        int          n;
        logic [31:0] held_lo;
        e = model(op, a, b);
        @(negedge clk);
        check({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.Op1       = a;
        bus.Op2       = b;
        bus.S_Op      = op;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.Op1      = $urandom;
        bus.Op2      = $urandom;
        bus.S_Op     = 4'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        check({tag, "/latency"}, 64'(n), 64'(e.lat));
        check({tag, "/R_Op"}, 64'(bus.R_Op), 64'(e.lo));
        check({tag, "/R_Hi"}, 64'(bus.R_Hi), 64'(e.hi));
        check({tag, "/ZF"},   64'(bus.ZF),   64'(e.zf));
        check({tag, "/DZ"},   64'(bus.DZ),   64'(e.dz));
        check({tag, "/ILL"},  64'(bus.ILL),  64'(e.ill));
        held_lo = e.lo;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.Op1      = $urandom;
            bus.S_Op     = 4'($urandom);
            @(negedge clk);
            check({tag, "/hold_R_Op"},      64'(bus.R_Op),      64'(held_lo));
            check({tag, "/hold_R_Hi"},      64'(bus.R_Hi),      64'(e.hi));
            check({tag, "/hold_in_ready"},  64'(bus.in_ready),  64'd0);
            check({tag, "/hold_out_valid"}, 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "/idle_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "/idle_in_ready"},  64'(bus.in_ready),  64'd1);
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.Op1       = '0;
        bus.Op2       = '0;
        bus.S_Op      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("reset/in_ready",  64'(bus.in_ready),  64'd1);
        check("reset/out_valid", 64'(bus.out_valid), 64'd0);
        check("reset/R_Op",      64'(bus.R_Op),      64'd0);
        check("reset/R_Hi",      64'(bus.R_Hi),      64'd0);
        check("reset/ZF",        64'(bus.ZF),        64'd1);
        check("reset/DZ",        64'(bus.DZ),        64'd0);
        check("reset/ILL",       64'(bus.ILL),       64'd0);
        rst = 1'b0;

        run_op("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'd1,       0);
        run_op("mul_hi",   4'd2,  32'h0001_0000, 32'h0003_0000, 0);
        run_op("div",      4'd3,  32'd100,       32'd7,       0);
        run_op("div_zero", 4'd3,  32'd5,         32'd0,       0);
        run_op("sra",      4'd9,  32'h8000_0000, 32'h24,      0);
        run_op("slt",      4'd6,  32'd3,         32'hFFFF_FFFF, 0);
        run_op("illegal",  4'd12, 32'h1234,      32'h5678,    0);
        run_op("sub",      4'd1,  32'd0,         32'd1,       0);
        run_op("mul_max",  4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_big",  4'd3,  32'hFFFF_FFFF, 32'd1,       0);
        run_op("stall",    4'd10, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 5);

        // Reset in the middle of a DIV discards it
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.Op1      = 32'd1000;
        bus.Op2      = 32'd3;
        bus.S_Op     = 4'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        check("abort/out_valid", 64'(bus.out_valid), 64'd0);
        check("abort/in_ready",  64'(bus.in_ready),  64'd1);
        check("abort/R_Op",      64'(bus.R_Op),      64'd0);
        check("abort/cycles",    64'(n),             64'd10);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_abort", 4'd0, 32'd2, 32'd2, 0);

        // Random ops with random stalls
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            run_op("rand", op, a, b, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
